// File: rtl/load_store_unit.sv
// Memory-access stage: steers stores, extracts and extends loads, and runs a ready handshake.
// Define LSU_MISALIGN_TRAP_EN to treat misaligned halfword and word accesses as errors.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_data_mem,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {StIdle, StMem, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;

    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] ld_shift;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    always_comb begin
        req_legal = 1'b0;
        if (i_we) begin
            req_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
        end else begin
            req_legal = (i_funct3 != 3'b011) && (i_funct3[2:1] != 2'b11);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((i_funct3[1:0] == 2'b01) && i_addr[0]) begin
            req_legal = 1'b0;
        end
        if ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00)) begin
            req_legal = 1'b0;
        end
`endif
    end

    // Lane steering depends only on access size, so loads reuse the store enables.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << i_addr[1:0];
                req_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                req_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = i_wdata;
            end
        endcase
    end

    always_comb begin
        ld_shift = i_mem_rdata >> {addr_q[1:0], 3'b000};
        ld_half  = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_value = {24'h0, ld_shift[7:0]};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'h0, ld_half};
            default: ld_value = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_req) state_d = req_legal ? StMem : StDone;
            StMem:  if (i_mem_ready) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        data_d   = data_q;
        if ((state_q == StIdle) && i_req) begin
            if (req_legal) begin
                we_d     = i_we;
                funct3_d = i_funct3;
                addr_d   = i_addr;
                be_d     = req_be;
                wdata_d  = req_wdata;
                err_d    = 1'b0;
            end else begin
                err_d    = 1'b1;
            end
        end
        if ((state_q == StMem) && i_mem_ready && !we_q) begin
            data_d = ld_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        o_busy      = (state_q != StIdle);
        o_done      = (state_q == StDone);
        o_mem_req   = (state_q == StMem);
        o_mem_we    = (state_q == StMem) && we_q;
        o_err       = err_q;
        o_mem_addr  = {addr_q[31:2], 2'b00};
        o_mem_be    = be_q;
        o_mem_wdata = wdata_q;
        o_data_mem  = data_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases with literal results, then random traffic
// compared every cycle against an access-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_busy, o_done, o_err, o_mem_req, o_mem_we;
    logic [31:0] o_data_mem, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ready = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_funct3   (i_funct3),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_data_mem (o_data_mem),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_be   (o_mem_be),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(i_mem_ready),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: what the outputs must be in the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, model_data = 32'h0;
    logic [3:0]  exp_be = 4'h0;

    // Captures from the last access, for the literal checks.
    int          req_cnt;
    logic        cap_err;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic legal_m(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic ok;
        if (we) ok = (f3 <= 3'd2);
        else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 % 4 == 1) && (a % 2 != 0)) ok = 1'b0;
        if ((f3 % 4 == 2) && (a % 4 != 0)) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [3:0] be_m(input logic [2:0] f3, input logic [31:0] a);
        int unsigned lane = a % 4;
        if (f3 % 4 == 0) return 4'(1 << lane);
        if (f3 % 4 == 1) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 % 4 == 0) return (wd % 256) * 32'h01010101;
        if (f3 % 4 == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] extract_m(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
        logic [31:0] v;
        if (f3 % 4 == 0) begin
            v = (rd >> (8 * (a % 4))) % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (f3 % 4 == 1) begin
            v = (rd >> (16 * ((a / 2) % 2))) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
            return v;
        end
        return rd;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(o_busy), 32'(exp_busy));
            check("done", 32'(o_done), 32'(exp_done));
            check("mem_req", 32'(o_mem_req), 32'(exp_req));
            check("mem_we", 32'(o_mem_we), 32'(exp_req & exp_we));
            check("data_mem", o_data_mem, model_data);
            if (exp_done) check("err", 32'(o_err), 32'(exp_err));
            if (exp_req) begin
                check("mem_addr", o_mem_addr, exp_addr);
                check("mem_be", 32'(o_mem_be), 32'(exp_be));
                if (exp_we) check("mem_wdata", o_mem_wdata, exp_wdata);
            end
        end
    end

    // Random request activity while busy; the DUT must ignore it.
    task automatic drive_junk();
        i_req    = 1'($urandom);
        i_we     = 1'($urandom);
        i_funct3 = 3'($urandom);
        i_addr   = $urandom;
        i_wdata  = $urandom;
    endtask

    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int d, input logic [31:0] rd);
        logic lg;
        lg = legal_m(we, f3, addr);
        req_cnt = 0;
        cap_err = 1'bx;
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        i_mem_ready = 1'($urandom); i_mem_rdata = $urandom;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
        @(negedge clk); req_cnt += int'(o_mem_req);
        @(posedge clk); #1;
        drive_junk();
        if (!lg) begin
            exp_busy = 1'b1; exp_done = 1'b1; exp_err = 1'b1;
            @(negedge clk); cap_err = o_err; req_cnt += int'(o_mem_req);
            @(posedge clk); #1;
        end else begin
            exp_busy = 1'b1; exp_req = 1'b1; exp_we = we;
            exp_addr = addr & 32'hFFFFFFFC; exp_be = be_m(f3, addr); exp_wdata = wdata_m(f3, wd);
            for (int k = 0; k <= d; k++) begin
                i_mem_ready = (k == d);
                i_mem_rdata = (k == d) ? rd : $urandom;
                @(negedge clk);
                req_cnt += int'(o_mem_req);
                cap_addr = o_mem_addr; cap_be = o_mem_be; cap_wdata = o_mem_wdata;
                @(posedge clk); #1;
                drive_junk();
            end
            exp_req = 1'b0; exp_done = 1'b1; exp_err = 1'b0;
            if (!we) model_data = extract_m(f3, addr, rd);
            i_mem_ready = 1'($urandom);
            @(negedge clk); cap_err = o_err; req_cnt += int'(o_mem_req);
            @(posedge clk); #1;
        end
        i_req = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_we", 32'(o_mem_we), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_mem_be", 32'(o_mem_be), 32'd0);
        check("rst_mem_wdata", o_mem_wdata, 32'd0);
        check("rst_data_mem", o_data_mem, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        do_access(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 32'h0);
        check("sw_addr", cap_addr, 32'h104);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_wdata", cap_wdata, 32'hDEADBEEF);
        check("sw_data_unchanged", o_data_mem, 32'h0);

        do_access(1'b0, 3'd0, 32'h203, 32'h0, 0, 32'h80FF0000);
        check("lb", o_data_mem, 32'hFFFFFF80);
        do_access(1'b0, 3'd4, 32'h203, 32'h0, 1, 32'h80FF0000);
        check("lbu", o_data_mem, 32'h00000080);

        do_access(1'b1, 3'd1, 32'h12, 32'h0000ABCD, 0, 32'h0);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        do_access(1'b0, 3'd1, 32'h12, 32'h0, 0, 32'h7FFF0000);
        check("lh", o_data_mem, 32'h00007FFF);

        do_access(1'b0, 3'd2, 32'h300, 32'h0, 3, 32'h01234567);
        check("lw_wait_req_cycles", 32'(req_cnt), 32'd4);
        check("lw_wait_addr", cap_addr, 32'h300);
        check("lw_wait_data", o_data_mem, 32'h01234567);

        do_access(1'b0, 3'd3, 32'h10, 32'h0, 0, 32'h0);
        check("ill_err", 32'(cap_err), 32'd1);
        check("ill_no_req", 32'(req_cnt), 32'd0);
        check("ill_data_kept", o_data_mem, 32'h01234567);

        do_access(1'b0, 3'd1, 32'h101, 32'h0, 0, 32'h12348765);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lh_mis_err", 32'(cap_err), 32'd1);
        check("lh_mis_data", o_data_mem, 32'h01234567);
`else
        check("lh_mis_err", 32'(cap_err), 32'd0);
        check("lh_mis_data", o_data_mem, 32'hFFFF8765);
`endif

        // Reset in the middle of a stalled transfer.
        chk_en = 1'b0;
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h40; i_mem_ready = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_data", o_data_mem, 32'd0);
        @(posedge clk); #1;
        i_mem_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_no_done", 32'(o_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_data = 32'h0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 3'd2, 32'h44, 32'h0, 0, 32'hCAFEF00D);
        check("post_rst_lw", o_data_mem, 32'hCAFEF00D);

        for (int n = 0; n < 300; n++) begin
            int gap;
            do_access(1'(|($urandom % 4)) ? 1'b0 : 1'b1, 3'($urandom), $urandom, $urandom,
                      int'($urandom_range(0, 3)), $urandom);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                i_mem_ready = 1'($urandom);
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
